// File: rtl/shake256_absorb_padder.sv
// ---------------------------------------------------------------------------
// shake256_absorb_padder
//
// Upstream feeder for the SHAKE256 sponge core. Packs a serial message bit
// stream into RATE-bit blocks, applies SHAKE domain padding (suffix 1111
// followed by pad10*1) and hands each block downstream over valid/ready.
// Stream bit k lands in block[k mod RATE]; the final padded block is flagged
// with block_last.
//
// Parameters:
//   RATE   rate in bits (>= 8)
//   CNT_W  bit-position counter width, 2**CNT_W > RATE
//
// Ports:
//   clk                in   rising-edge clock
//   reset              in   asynchronous active-high reset
//   enable             in   serial_in carries a message bit this cycle
//   serial_in          in   message bit, stream order
//   serial_end_signal  in   level, message complete (same-cycle bit is last)
//   in_ready           out  padder accepts a bit / end this cycle
//   block              out  RATE-bit rate block
//   block_valid        out  block is valid
//   block_ready        in   downstream accepts (transfer = valid & ready)
//   block_last         out  block is the final padded block of the message
//   msg_bits           out  [31:0] accepted message bit count (optional)
//
// Build option:
//   SHAKE256_PAD_LENCNT_EN  defined -> adds msg_bits, a saturating count of
//                           accepted bits for the current message.
//
// FSM states:
//   state       | meaning
//   ------------+------------------------------------------------------------
//   COLLECT     | accepting bits into the buffer, in_ready = 1
//   EMIT_DATA   | full data block offered, not last
//   EMIT_PAD1   | padded block offered, last unless padding spills over
//   EMIT_PAD2   | spill block carrying remaining padding, last
//   WAIT_LOW    | message done, wait for serial_end_signal to drop
// ---------------------------------------------------------------------------
module shake256_absorb_padder #(
    parameter int RATE  = 1088,
    parameter int CNT_W = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            serial_in,
    input  logic            serial_end_signal,
    output logic            in_ready,
    output logic [RATE-1:0] block,
    output logic            block_valid,
    input  logic            block_ready,
    output logic            block_last
`ifdef SHAKE256_PAD_LENCNT_EN
    ,
    output logic [31:0]     msg_bits
`endif
);

    typedef enum logic [2:0] {
        S_COLLECT   = 3'd0,
        S_EMIT_DATA = 3'd1,
        S_EMIT_PAD1 = 3'd2,
        S_EMIT_PAD2 = 3'd3,
        S_WAIT_LOW  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(RATE - 1);
    localparam logic [CNT_W-1:0] FULL_POS  = CNT_W'(RATE);
    localparam logic [CNT_W-1:0] SHORT_MAX = CNT_W'(RATE - 6);

    // Number of suffix ones that overflow into the spill block is
    // pos + 5 - RATE; only its low 3 bits matter (range 0..4), so the
    // constant part is folded into a mod-8 offset.
    localparam int         SPILL_OFS_I = ((5 - RATE) % 8 + 8) % 8;
    localparam logic [2:0] SPILL_OFS   = 3'(SPILL_OFS_I);

    // Five ones: SHAKE suffix 1111 plus the leading 1 of pad10*1.
    localparam logic [RATE-1:0] SUFFIX = {{(RATE-5){1'b0}}, 5'h1F};
    // Closing 1 of pad10*1.
    localparam logic [RATE-1:0] MSB    = {1'b1, {(RATE-1){1'b0}}};

    state_t            state_q;
    state_t            state_d;
    logic [RATE-1:0]   block_q;
    logic [CNT_W-1:0]  pos_q;
    logic              end_pend_q;
    logic              long_q;
    logic [2:0]        spill_q;

    logic              bit_acc;
    logic              end_acc;
    logic              xfer;
    logic [CNT_W-1:0]  pos_eff;
    logic              pad_short;
    logic [RATE-1:0]   data_w;
    logic [RATE-1:0]   pad_blk;
    logic [RATE-1:0]   spill_blk;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    assign bit_acc = enable & (state_q == S_COLLECT);
    assign end_acc = serial_end_signal & (state_q == S_COLLECT);
    assign xfer    = block_valid & block_ready;

    // Position after any bit accepted in the same cycle as the end.
    assign pos_eff = pos_q + CNT_W'(bit_acc);

    // Buffer with the current bit merged in. The buffer is zero at every
    // unwritten position, so only the addressed bit changes.
    always_comb begin
        data_w = block_q;
        if (bit_acc) begin
            data_w[pos_q] = serial_in;
        end
    end

    // Padding fits in this block when the five ones and the closing 1 all
    // land at or below RATE-1; otherwise the ones are cut at the block edge
    // by the shift and the remainder goes to the spill block.
    assign pad_short = (pos_eff <= SHORT_MAX);
    assign pad_blk   = data_w | (SUFFIX << pos_eff) | (pad_short ? MSB : '0);
    assign spill_blk = (SUFFIX >> (3'd5 - spill_q)) | MSB;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: begin
                if (end_acc) begin
                    state_d = (pos_eff == FULL_POS) ? S_EMIT_DATA : S_EMIT_PAD1;
                end else if (bit_acc && (pos_q == LAST_POS)) begin
                    state_d = S_EMIT_DATA;
                end
            end
            S_EMIT_DATA: begin
                if (xfer) begin
                    state_d = end_pend_q ? S_EMIT_PAD1 : S_COLLECT;
                end
            end
            S_EMIT_PAD1: begin
                if (xfer) begin
                    state_d = long_q ? S_EMIT_PAD2 : S_WAIT_LOW;
                end
            end
            S_EMIT_PAD2: begin
                if (xfer) begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!serial_end_signal) begin
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (decoded from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = 1'b0;
        block_valid = 1'b0;
        block_last  = 1'b0;
        case (state_q)
            S_COLLECT: begin
                in_ready = 1'b1;
            end
            S_EMIT_DATA: begin
                block_valid = 1'b1;
            end
            S_EMIT_PAD1: begin
                block_valid = 1'b1;
                block_last  = ~long_q;
            end
            S_EMIT_PAD2: begin
                block_valid = 1'b1;
                block_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign block = block_q;

    // ------------------------------------------------------------------
    // Buffer, bit position and padding bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block_q    <= '0;
            pos_q      <= '0;
            end_pend_q <= 1'b0;
            long_q     <= 1'b0;
            spill_q    <= '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (end_acc) begin
                        pos_q <= '0;
                        if (pos_eff == FULL_POS) begin
                            // Final bit filled the block: send it as data,
                            // then a padding-only block.
                            block_q    <= data_w;
                            end_pend_q <= 1'b1;
                        end else begin
                            block_q    <= pad_blk;
                            end_pend_q <= 1'b0;
                            long_q     <= ~pad_short;
                            spill_q    <= pos_eff[2:0] + SPILL_OFS;
                        end
                    end else if (bit_acc) begin
                        block_q <= data_w;
                        if (pos_q == LAST_POS) begin
                            pos_q      <= '0;
                            end_pend_q <= 1'b0;
                        end else begin
                            pos_q <= pos_q + CNT_W'(1);
                        end
                    end
                end
                S_EMIT_DATA: begin
                    if (xfer) begin
                        end_pend_q <= 1'b0;
                        if (end_pend_q) begin
                            block_q <= SUFFIX | MSB;
                            long_q  <= 1'b0;
                        end else begin
                            block_q <= '0;
                        end
                    end
                end
                S_EMIT_PAD1: begin
                    if (xfer && long_q) begin
                        block_q <= spill_blk;
                    end
                end
                S_WAIT_LOW: begin
                    if (!serial_end_signal) begin
                        block_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHAKE256_PAD_LENCNT_EN
    // ------------------------------------------------------------------
    // Message length counter: saturating, holds through WAIT_LOW and
    // restarts when the next message may begin.
    // ------------------------------------------------------------------
    logic [31:0] msg_bits_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_bits_q <= '0;
        end else if ((state_q == S_WAIT_LOW) && !serial_end_signal) begin
            msg_bits_q <= '0;
        end else if (bit_acc && (msg_bits_q != 32'hFFFF_FFFF)) begin
            msg_bits_q <= msg_bits_q + 32'd1;
        end
    end

    assign msg_bits = msg_bits_q;
`endif

endmodule

// File: tb/tb_shake256_absorb_padder.sv
module tb_shake256_absorb_padder;

    localparam int RATE  = 1088;
    localparam int CNT_W = 11;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            serial_in;
    logic            serial_end_signal;
    logic            in_ready;
    logic [RATE-1:0] block;
    logic            block_valid;
    logic            block_ready;
    logic            block_last;
`ifdef SHAKE256_PAD_LENCNT_EN
    logic [31:0]     msg_bits;
`endif

    int checks   = 0;
    int failures = 0;

    logic            msg_q[$];
    logic [RATE-1:0] exp_q[$];
    logic [RATE-1:0] got_q[$];
    logic            got_last_q[$];

    shake256_absorb_padder #(.RATE(RATE), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .serial_in         (serial_in),
        .serial_end_signal (serial_end_signal),
        .in_ready          (in_ready),
        .block             (block),
        .block_valid       (block_valid),
        .block_ready       (block_ready),
        .block_last        (block_last)
`ifdef SHAKE256_PAD_LENCNT_EN
        ,
        .msg_bits          (msg_bits)
`endif
    );

    always #5 clk = ~clk;

    function automatic int first_diff(input logic [RATE-1:0] a, input logic [RATE-1:0] b);
        for (int k = 0; k < RATE; k++) begin
            if (a[k] !== b[k]) return k;
        end
        return -1;
    endfunction

    // Reference: padded stream = message, five ones, zeros, final one,
    // total length rounded up to a multiple of RATE; sliced into blocks.
    task automatic build_expected(input int len);
        int n;
        int idx;
        logic [RATE-1:0] b;
        exp_q.delete();
        n = (len + 6 + RATE - 1) / RATE;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < RATE; k++) begin
                idx = i * RATE + k;
                if (idx < len)              b[k] = msg_q[idx];
                else if (idx < len + 5)     b[k] = 1'b1;
                else if (idx == n*RATE - 1) b[k] = 1'b1;
                else                        b[k] = 1'b0;
            end
            exp_q.push_back(b);
        end
    endtask

    // Streams msg_q into the DUT with random gaps and backpressure, checks
    // every offered block against the reference, then drops the end level.
    task automatic run_msg(input string name, input bit end_with_last,
                           input int gap_pct, input int stall_pct);
        int len;
        int n;
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int d;
        bit end_sent = 0;
        bit exp_valid_next = 0;
        logic [RATE-1:0] e;
        logic [63:0] glo;
        logic [63:0] elo;

        len = msg_q.size();
        if (len == 0) end_with_last = 0;
        build_expected(len);
        n = exp_q.size();
        got_q.delete();
        got_last_q.delete();

        while (got < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (exp_valid_next) begin
                checks++;
                if (block_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL %s latency: block_valid=%b required=1", name, block_valid);
                end
                exp_valid_next = 0;
            end
            if (block_valid === 1'b1) begin
                e = exp_q[got];
                checks++;
                if (block !== e) begin
                    failures++;
                    d = first_diff(block, e);
                    glo = block[63:0];
                    elo = e[63:0];
                    $display("FAIL %s block%0d data: first_diff_bit=%0d got_lo=%h required_lo=%h",
                             name, got, d, glo, elo);
                end
                checks++;
                if (block_last !== (got == n - 1)) begin
                    failures++;
                    $display("FAIL %s block%0d last: got=%b required=%b", name, got, block_last, (got == n - 1));
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s in_ready_while_valid: got=%b required=0", name, in_ready);
                end
                block_ready = ($urandom_range(99) >= stall_pct);
                if (block_ready) begin
                    got_q.push_back(block);
                    got_last_q.push_back(block_last);
                    got++;
                end
            end else begin
                block_ready = 1'($urandom_range(1));
            end

            if (in_ready === 1'b1 && !end_sent) begin
                if (idx < len && $urandom_range(99) >= gap_pct) begin
                    enable = 1'b1;
                    serial_in = msg_q[idx];
                    idx++;
                    serial_end_signal = end_with_last && (idx == len);
                    if (serial_end_signal || (idx % RATE == 0)) exp_valid_next = 1;
                    if (serial_end_signal) end_sent = 1;
                end else if (idx == len && $urandom_range(99) >= gap_pct) begin
                    enable = 1'b0;
                    serial_in = 1'($urandom_range(1));
                    serial_end_signal = 1'b1;
                    end_sent = 1;
                    exp_valid_next = 1;
                end else begin
                    enable = 1'b0;
                    serial_in = 1'($urandom_range(1));
                    serial_end_signal = 1'b0;
                end
            end
        end

        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL %s timeout: blocks_got=%0d required=%0d", name, got, n);
        end

        // End still held: must sit idle with nothing offered.
        repeat (3) begin
            @(negedge clk);
            block_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b0 || block_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s wait_low: in_ready=%b block_valid=%b required 0/0", name, in_ready, block_valid);
            end
        end
`ifdef SHAKE256_PAD_LENCNT_EN
        checks++;
        if (msg_bits !== 32'(len)) begin
            failures++;
            $display("FAIL %s msg_bits: got=%0d required=%0d", name, msg_bits, len);
        end
`endif
        serial_end_signal = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || block !== '0) begin
            failures++;
            $display("FAIL %s back_to_collect: in_ready=%b block_zero=%b required 1/1", name, in_ready, (block == '0));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || block_valid !== 1'b0 || block_last !== 1'b0 || block !== '0) begin
            failures++;
            $display("FAIL reset_values: in_ready=%b valid=%b last=%b block_zero=%b required 1/0/0/1",
                     in_ready, block_valid, block_last, (block == '0));
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_length();
        logic [RATE-1:0] b0;
        msg_q.delete();
        run_msg("zero_len", 0, 20, 30);
        b0 = (got_q.size() > 0) ? got_q[0] : '0;
        checks++;
        if (got_q.size() != 1 || b0[7:0] !== 8'h1F || b0[1087:1080] !== 8'h80 ||
            b0[1079:8] !== '0 || got_last_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_literal: blocks=%0d lo=%h hi=%h required 1/1f/80", got_q.size(), b0[7:0], b0[1087:1080]);
        end
    endtask

    task automatic test_eight_bits();
        logic [RATE-1:0] b0;
        logic [7:0] pat;
        pat = 8'hA5;
        msg_q.delete();
        for (int i = 0; i < 8; i++) msg_q.push_back(pat[i]);
        run_msg("eight_bits", 1, 0, 0);
        b0 = (got_q.size() > 0) ? got_q[0] : '0;
        checks++;
        if (got_q.size() != 1 || b0[15:0] !== 16'h1FA5 || b0[1087:1080] !== 8'h80 ||
            b0[1079:16] !== '0 || got_last_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL eight_bits_literal: lo=%h hi=%h required 1fa5/80", b0[15:0], b0[1087:1080]);
        end
    endtask

    task automatic test_1080_ones();
        logic [RATE-1:0] b0;
        msg_q.delete();
        for (int i = 0; i < 1080; i++) msg_q.push_back(1'b1);
        run_msg("ones_1080", 0, 0, 20);
        b0 = (got_q.size() > 0) ? got_q[0] : '0;
        checks++;
        if (got_q.size() != 1 || b0[1087:1080] !== 8'h9F || b0[1079:0] !== {1080{1'b1}} ||
            got_last_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL ones_1080_literal: blocks=%0d hi=%h required 1/9f", got_q.size(), b0[1087:1080]);
        end
    endtask

    task automatic test_1084_zeros();
        logic [RATE-1:0] b0;
        logic [RATE-1:0] b1;
        msg_q.delete();
        for (int i = 0; i < 1084; i++) msg_q.push_back(1'b0);
        run_msg("zeros_1084", 0, 0, 20);
        b0 = (got_q.size() > 0) ? got_q[0] : '0;
        b1 = (got_q.size() > 1) ? got_q[1] : '0;
        checks++;
        if (got_q.size() != 2 || b0 !== {4'hF, {1084{1'b0}}} || got_last_q[0] !== 1'b0) begin
            failures++;
            $display("FAIL zeros_1084_block0: blocks=%0d hi=%h required 2/f", got_q.size(), b0[1087:1084]);
        end
        checks++;
        if (b1 !== {1'b1, {1086{1'b0}}, 1'b1} || got_last_q[got_last_q.size()-1] !== 1'b1) begin
            failures++;
            $display("FAIL zeros_1084_block1: lo=%h hi=%h required 01/80", b1[7:0], b1[1087:1080]);
        end
    endtask

    task automatic test_1088_ones();
        logic [RATE-1:0] b0;
        logic [RATE-1:0] b1;
        msg_q.delete();
        for (int i = 0; i < 1088; i++) msg_q.push_back(1'b1);
        run_msg("ones_1088", 1, 0, 20);
        b0 = (got_q.size() > 0) ? got_q[0] : '0;
        b1 = (got_q.size() > 1) ? got_q[1] : '0;
        checks++;
        if (got_q.size() != 2 || b0 !== {RATE{1'b1}} || got_last_q[0] !== 1'b0) begin
            failures++;
            $display("FAIL ones_1088_block0: blocks=%0d all_ones=%b required 2/1", got_q.size(), (b0 == {RATE{1'b1}}));
        end
        checks++;
        if (b1[7:0] !== 8'h1F || b1[1087:1080] !== 8'h80 || b1[1079:8] !== '0 ||
            got_last_q[got_last_q.size()-1] !== 1'b1) begin
            failures++;
            $display("FAIL ones_1088_block1: lo=%h hi=%h required 1f/80", b1[7:0], b1[1087:1080]);
        end
    endtask

    task automatic test_backpressure();
        logic [RATE-1:0] snap;
        logic [RATE-1:0] e;
        msg_q.delete();
        for (int i = 0; i < 30; i++) msg_q.push_back(1'($urandom_range(1)));
        build_expected(30);
        e = exp_q[0];
        block_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            enable = 1'b1;
            serial_in = msg_q[i];
            serial_end_signal = 1'b0;
        end
        @(negedge clk);
        enable = 1'b0;
        serial_end_signal = 1'b1;
        @(negedge clk);
        snap = block;
        checks++;
        if (block_valid !== 1'b1 || snap !== e) begin
            failures++;
            $display("FAIL stall_block: valid=%b first_diff_bit=%0d required 1/-1", block_valid, first_diff(snap, e));
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (block !== snap || in_ready !== 1'b0 || block_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold cycle %0d: stable=%b in_ready=%b valid=%b required 1/0/1",
                         c, (block == snap), in_ready, block_valid);
            end
            enable = ~enable;
            serial_in = 1'($urandom_range(1));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (block_valid !== 1'b0 || in_ready !== 1'b1 || block_last !== 1'b0 || block !== '0) begin
            failures++;
            $display("FAIL reset_mid_wait: valid=%b in_ready=%b last=%b block_zero=%b required 0/1/0/1",
                     block_valid, in_ready, block_last, (block == '0));
        end
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        serial_in = 1'b0;
        serial_end_signal = 1'b0;
        @(negedge clk);
        msg_q.delete();
        for (int i = 0; i < 12; i++) msg_q.push_back(1'($urandom_range(1)));
        run_msg("after_reset", 1, 10, 10);
    endtask

    task automatic test_random();
        int len;
        int cat;
        string nm;
        for (int m = 0; m < 10; m++) begin
            cat = $urandom_range(3);
            case (cat)
                0:       len = $urandom_range(40);
                1:       len = $urandom_range(RATE + 2, RATE - 8);
                2:       len = $urandom_range(2*RATE + 2, 2*RATE - 8);
                default: len = $urandom_range(RATE - 9, 41);
            endcase
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(1'($urandom_range(1)));
            nm = $sformatf("rand%0d_len%0d", m, len);
            run_msg(nm, 1'($urandom_range(1)), $urandom_range(30), $urandom_range(50));
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        serial_in = 1'b0;
        serial_end_signal = 1'b0;
        block_ready = 1'b0;
        test_reset();
        test_zero_length();
        test_eight_bits();
        test_1080_ones();
        test_1084_zeros();
        test_1088_ones();
        test_backpressure();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
